// File: rtl/stack_datapath_if.sv
// Command/status bundle between the stack-machine control unit and the operand stack.
// master: drives command fields and err_clr, observes stack status and sticky flags.
// slave : the datapath; samples commands and drives top/depth/empty/full/flags.
interface stack_datapath_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
);
  localparam int DW = $clog2(DEPTH + 1);

  logic             cmd_valid;
  logic             push;
  logic             pop;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] push_data;
  logic             err_clr;

  logic [WIDTH-1:0] top;
  logic [DW-1:0]    depth;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;
  logic             illegal;

  modport master (
    output cmd_valid, push, pop, alu_op, push_data, err_clr,
    input  top, depth, empty, full, overflow, underflow, illegal
  );

  modport slave (
    input  cmd_valid, push, pop, alu_op, push_data, err_clr,
    output top, depth, empty, full, overflow, underflow, illegal
  );
endinterface

// File: rtl/stack_datapath.sv
// Operand stack + ALU executing push/pop/alu_op commands, one command per cycle.
// Latency: 1 cycle from command edge to top/depth; no backpressure, every valid command is accepted.
// Ports: clock, reset (async active-low), bus (slave modport: command in, status/sticky flags out).
module stack_datapath #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic            clock,
  input  logic            reset,
  stack_datapath_if.slave bus
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DW-1:0]    depth_q, depth_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             ill_q, ill_d;

  logic [AW-1:0]    push_idx, tos_idx, nos_idx;
  logic [WIDTH-1:0] tos, nos, alu_res;
  logic [1:0]       n_act;
  logic             is_empty, is_full, op_act, op_undef, cmd_ill;
  logic             do_push, do_pop, do_alu, ovf_ev, unf_ev;

  always_comb begin
    // Indices wrap modulo DEPTH: when full, push_idx is 0 but is never used for a write.
    push_idx = depth_q[AW-1:0];
    tos_idx  = push_idx - AW'(1);
    nos_idx  = push_idx - AW'(2);
    tos      = mem_q[tos_idx];
    nos      = mem_q[nos_idx];

    is_empty = (depth_q == '0);
    is_full  = (depth_q == DW'(DEPTH));
    op_act   = (bus.alu_op != OP_NONE);
    op_undef = (bus.alu_op > OP_NOR);
    n_act    = {1'b0, bus.push} + {1'b0, bus.pop} + {1'b0, op_act};

    // Illegal commands are rejected before any capacity check.
    cmd_ill  = bus.cmd_valid && ((n_act > 2'd1) || op_undef);
    ovf_ev   = bus.cmd_valid && !cmd_ill && bus.push && is_full;
    unf_ev   = bus.cmd_valid && !cmd_ill &&
               ((bus.pop && is_empty) || (op_act && (depth_q < DW'(2))));

    do_push  = bus.cmd_valid && !cmd_ill && bus.push && !is_full;
    do_pop   = bus.cmd_valid && !cmd_ill && bus.pop && !is_empty;
    do_alu   = bus.cmd_valid && !cmd_ill && op_act && (depth_q >= DW'(2));

    alu_res = '0;
    case (bus.alu_op)
      OP_AND:  alu_res = nos & tos;
      OP_OR:   alu_res = nos | tos;
      OP_ADD:  alu_res = nos + tos;
      OP_SUB:  alu_res = nos - tos;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(nos) < $signed(tos))};
      OP_NOR:  alu_res = ~(nos | tos);
      default: alu_res = '0;
    endcase

    depth_d = depth_q;
    if (do_push) begin
      depth_d = depth_q + DW'(1);
    end else if (do_pop || do_alu) begin
      depth_d = depth_q - DW'(1);
    end

    // A new error in the same cycle as err_clr leaves the flag set.
    ovf_d = (ovf_q && !bus.err_clr) || ovf_ev;
    unf_d = (unf_q && !bus.err_clr) || unf_ev;
    ill_d = (ill_q && !bus.err_clr) || cmd_ill;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      ill_q   <= ill_d;
    end
  end

  // Storage is not reset; depth alone defines which entries are valid.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[push_idx] <= bus.push_data;
    end else if (do_alu) begin
      mem_q[nos_idx] <= alu_res;
    end
  end

  assign bus.top       = is_empty ? '0 : tos;
  assign bus.depth     = depth_q;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.illegal   = ill_q;
endmodule

// File: doc/stack_datapath.md
Name: stack_datapath

Overview:
- Operand stack plus ALU that executes the push/pop/alu_op commands produced by the stack-machine control unit.
- Holds a LIFO of WIDTH-bit words with push of an immediate and pop of the top.
- Binary ALU operations replace the top two entries (NOS op TOS) with one result.
- Single-cycle command execution; sticky error flags report overflow, underflow and illegal command combinations.

Parameters:
- WIDTH, 32, data word width.
- DEPTH, 16, number of stack entries (power of two, >=2).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- cmd_valid  input  1  command fields sampled only when 1.
- push  input  1  push push_data onto stack.
- pop  input  1  discard top entry.
- alu_op  input  4  ALU operation; 0000 = none.
- push_data  input  WIDTH  immediate value for push.
- top  output  WIDTH  current top-of-stack; 0 when empty.
- depth  output  $clog2(DEPTH+1)  number of valid entries.
- empty  output  1  depth == 0.
- full  output  1  depth == DEPTH.
- overflow  output  1  sticky: push attempted while full.
- underflow  output  1  sticky: pop on empty, or ALU op with depth < 2.
- illegal  output  1  sticky: conflicting command or undefined alu_op.
- err_clr  input  1  synchronous clear of the three sticky flags.

Behaviour:
- Reset (reset==0, asynchronous): depth=0, overflow=underflow=illegal=0, empty=1, full=0, top=0. Storage contents need not be cleared. Reset asserted mid-operation aborts the command in flight; no partial update survives.
- Command decode when cmd_valid=1 at a rising edge. Results are visible on top/depth the cycle after that edge (latency 1). When cmd_valid=0, state holds.
- alu_op encoding:
  - 0001 AND
  - 0010 OR
  - 0011 ADD
  - 0100 SUB
  - 0101 SLT
  - 0110 NOR
  - 0111–1111 undefined.
- Legal commands (exactly one active):
  - push=1, pop=0, alu_op=0: mem[depth] <= push_data; depth+1.
  - pop=1, push=0, alu_op=0: depth-1; popped value not returned.
  - alu_op!=0, push=pop=0: a = entry depth-2 (NOS), b = entry depth-1 (TOS); mem[depth-2] <= a op b; depth-1.
  - push=pop=0, alu_op=0: no-op.
- ALU width rules:
  - ADD/SUB are modulo 2^WIDTH; no carry or overflow reporting.
  - SUB = a - b.
  - SLT = 1 if a < b signed (two's complement), else 0, zero-extended.
  - NOR = ~(a | b).
- Error cases: state unchanged (depth, storage) and flag set.
  - push when full -> overflow.
  - pop when empty, or ALU op when depth<2 -> underflow.
  - More than one of {push, pop, alu_op!=0}, or undefined alu_op -> illegal. illegal takes priority; overflow/underflow are not evaluated for such commands.
- Sticky flags remain 1 until reset or err_clr=1.
  - err_clr and a new error in the same cycle: the flag ends at 1 (set wins).
  - err_clr does not affect stack state and may coincide with a legal command.
- Derived outputs:
  - top = mem[depth-1] when depth>0, else 0.
  - empty and full are derived from depth, with no extra latency.
- Back-to-back commands on consecutive cycles are supported with no bubbles; each sees the state left by the previous one.

Test Plan:
- Push 5, push 7, ADD on consecutive cycles -> after 3rd edge top=12, depth=1, no flags.
- Push 3, push 10, SUB -> top=0xFFFFFFF9 (-7); then push 0xFFFFFFFF, push 1, SLT -> top=1, depth=2 (0xFFFFFFF9 below).
- 16 pushes of values 1..16 -> full=1, top=16; 17th push (99) -> overflow=1, depth=16, top=16; err_clr -> overflow=0.
- From reset, pop -> underflow=1, depth=0; push 4 then AND -> underflow stays 1, depth=1, top=4.
- push=1 and pop=1 together with depth=2 -> illegal=1, depth/top unchanged; alu_op=1010 -> illegal=1, no state change.
- Push 0xA, 0xB, drop reset low asynchronously mid-cycle -> depth=0, top=0, flags 0 immediately; after release, push 0xC -> top=0xC, depth=1.
